alu_sequencer: RTL and testbench
================================

# alu_sequencer

Registered controller in front of the 24-bit ALU datapath. Accepts one operation at a time over a valid/ready handshake and latches the operands. It drives the 3-bit result-select code, computes single-cycle ops in one clock, and runs MUL as an iterative shift-add over WIDTH clocks. The result is held with status flags until the consumer (register-file writeback) accepts it.

## Interface
- WIDTH, 24, operand/result width in bits; legal range 2..32.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  request present.
- IN_READY  out  1  sequencer can accept; equals (state == IDLE).
- OPCODE  in  3  000 AND, 001 OR, 010 ADD, 011 LESS (signed), 100 MUL, 101 XOR, 110/111 illegal.
- OPERAND_A  in  WIDTH  first operand.
- OPERAND_B  in  WIDTH  second operand.
- SELECTOR  out  3  registered result-select code of the op in flight.
- BUSY  out  1  high in EXEC or MUL state.
- OUT_VALID  out  1  result and flags valid; high only in DONE.
- OUT_READY  in  1  consumer accepts the result.
- RESULT  out  WIDTH  operation result.
- ZERO  out  1  RESULT == 0.
- CARRY  out  1  carry-out of ADD; 0 for every other op.
- ILLEGAL  out  1  OPCODE was 110 or 111.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- Accept: a transfer occurs on a rising edge with IN_VALID && IN_READY.
  - OPCODE, OPERAND_A and OPERAND_B are latched and SELECTOR is loaded with OPCODE.
  - Inputs may change freely afterwards.
- IDLE to EXEC on accept of any non-MUL opcode, including illegal opcodes.
- IDLE to MUL on accept of OPCODE 100. On entry: accumulator = 0, count = 0, multiplicand = A, multiplier = B.
- EXEC to DONE unconditionally, registering RESULT and flags:
  - AND, OR, XOR: bitwise.
  - ADD: A+B mod 2^WIDTH; CARRY = bit WIDTH of the sum.
  - LESS: RESULT = 1 if signed(A) < signed(B), else 0.
  - Illegal: RESULT = 0, ILLEGAL = 1, ZERO = 1.
- MUL: each cycle,
  - if multiplier[0] is set, accumulator += multiplicand (mod 2^WIDTH);
  - multiplicand shifts left by 1, multiplier shifts right by 1, count increments.
  - After the WIDTH-th iteration, go to DONE with RESULT = low WIDTH bits of A*B (unsigned; identical to two's-complement low half).
- DONE: outputs hold stable while OUT_READY is low. On an edge with OUT_READY high, go to IDLE.
- RESULT, flags and SELECTOR keep their last values in IDLE. Consumers must sample them only with OUT_VALID.
- IN_VALID is ignored outside IDLE. No request is queued.

## Timing
- Reset values, asserted asynchronously while RST_N is low:
  - state = IDLE, IN_READY = 1, BUSY = 0, OUT_VALID = 0;
  - SELECTOR = 000, RESULT = 0, ZERO = 0, CARRY = 0, ILLEGAL = 0;
  - internal accumulator and count = 0.
- Reset mid-operation (EXEC, MUL or DONE) aborts the op with no result delivered. The first accept is possible on the first rising edge after RST_N deasserts.
- Latency, counted from the accepting edge to the edge that sets OUT_VALID:
  - non-MUL: 2 edges (accept, EXEC);
  - MUL: WIDTH+1 edges (24 iterations plus accept for the default WIDTH).
- Minimum issue interval is 3 cycles for non-MUL ops when OUT_READY is held high. The DONE cycle and the IDLE cycle are not overlapped.
- OUT_READY high already on the first DONE cycle: exactly one cycle of OUT_VALID.
- BUSY and OUT_VALID are never high together. IN_READY and OUT_VALID are never high together.

## Structure
- Shared package alu_pkg:
  - opcode constants OP_AND..OP_XOR;
  - state encoding (2-bit) IDLE = 00, EXEC = 01, MUL = 10, DONE = 11;
  - default WIDTH.
- alu_sequencer holds the FSM, the handshake and the single-cycle ops.
- One sub-module: alu_mul_iter, the shift-add datapath.
  - Inputs: start, A, B.
  - Outputs: product, done; done pulses on the WIDTH-th iteration.
  - It is instantiated once, and the FSM waits on done.

## Test plan
- Reset mid-MUL: accept MUL 7*9, assert RST_N low on the 5th MUL cycle -> all outputs return to reset values immediately; the next ADD 1+1 gives RESULT 2.
- ADD 0xFFFFFF + 0x000001 with OUT_READY = 1 -> OUT_VALID 2 edges after accept for 1 cycle; RESULT 0, ZERO 1, CARRY 1, SELECTOR 010.
- LESS A = 0x800000, B = 0x000001 -> RESULT 1; swap the operands -> RESULT 0; CARRY 0 both times.
- MUL 0x000123 * 0x000456 -> RESULT 0x04EDC2 exactly 25 edges after accept; BUSY high for 24 cycles; IN_READY low throughout.
- Back-pressure: XOR 0xAAAAAA ^ 0x555555 with OUT_READY low for 10 cycles -> RESULT 0xFFFFFF and OUT_VALID held stable; IN_VALID pulses ignored; the transfer occurs on the first OUT_READY edge.
- OPCODE 111 with A = 5, B = 3 -> ILLEGAL 1, RESULT 0, ZERO 1; OPCODE 110 likewise; the next legal OR 5|3 gives RESULT 7 with ILLEGAL 0.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer slice: default datapath width,
// opcode encodings, FSM state encoding and a small opcode-legality helper.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_WIDTH = 24;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_LESS = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Codes 110 and 111 are the only undefined opcodes.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// ----------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier producing the low WIDTH bits of A*B.
// One iteration per clock after the start edge; o_done pulses combinationally
// during the WIDTH-th iteration, and o_product carries the final sum in that
// same cycle so the caller can register it on the finishing edge.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_start    load operands and clear accumulator/count
//   i_a        multiplicand loaded on start
//   i_b        multiplier loaded on start
//   o_product  accumulator value after the current iteration
//   o_done     high during the WIDTH-th iteration
// ----------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_product,
    output logic             o_done
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;
    logic             r_run;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    // Partial-product add for the current multiplier bit.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = r_acc + r_mcand;
        end else begin
            w_acc_next = r_acc;
        end
    end

    assign w_last    = r_run && (r_count == LAST);
    assign o_done    = w_last;
    assign o_product = w_acc_next;

    // Operand load on start, then one shift-add step per clock while running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_count  <= {CW{1'b0}};
            r_run    <= 1'b0;
        end else if (i_start) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_count  <= {CW{1'b0}};
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_count  <= r_count + {{(CW-1){1'b0}}, 1'b1};
            r_run    <= !w_last;
        end else begin
            r_acc    <= r_acc;
            r_mcand  <= r_mcand;
            r_mplier <= r_mplier;
            r_count  <= r_count;
            r_run    <= r_run;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
// Registered controller in front of the ALU datapath. Accepts one operation
// over a valid/ready handshake, latches operands, executes single-cycle ops in
// EXEC or hands MUL to the iterative multiplier, then holds the result and
// flags in DONE until the consumer accepts.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   request present
//   o_in_ready   sequencer can accept (state IDLE)
//   i_opcode     3-bit operation code
//   i_operand_a  first operand
//   i_operand_b  second operand
//   o_selector   registered result-select code of the op in flight
//   o_busy       high in EXEC or MUL
//   o_out_valid  result and flags valid (state DONE)
//   i_out_ready  consumer accepts the result
//   o_result     operation result
//   o_zero       result is zero
//   o_carry      carry-out of ADD, 0 otherwise
//   o_illegal    opcode was 110 or 111
// ----------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_opcode,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic [2:0]       o_selector,
    output logic             o_busy,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_illegal
);

    state_t           r_state;
    state_t           w_state_next;

    logic [2:0]       r_selector;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_illegal;

    logic             w_accept;
    logic             w_mul_start;
    logic [WIDTH-1:0] w_mul_product;
    logic             w_mul_done;

    logic [WIDTH:0]   w_sum;
    logic             w_less;
    logic [WIDTH-1:0] w_exec_result;
    logic             w_exec_carry;
    logic             w_exec_illegal;

    assign w_accept    = i_in_valid && (r_state == ST_IDLE);
    assign w_mul_start = w_accept && (i_opcode == OP_MUL);

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_busy      = (r_state == ST_EXEC) || (r_state == ST_MUL);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_selector  = r_selector;
    assign o_result    = r_result;
    assign o_zero      = r_zero;
    assign o_carry     = r_carry;
    assign o_illegal   = r_illegal;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (w_mul_start),
        .i_a       (i_operand_a),
        .i_b       (i_operand_b),
        .o_product (w_mul_product),
        .o_done    (w_mul_done)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; IN_VALID only matters in IDLE, so nothing is queued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_in_valid) begin
                    w_state_next = (i_opcode == OP_MUL) ? ST_MUL : ST_EXEC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_DONE;
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_MUL;
                end
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch: opcode doubles as the result-select code.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_selector <= 3'b000;
            r_a        <= {WIDTH{1'b0}};
            r_b        <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_selector <= i_opcode;
            r_a        <= i_operand_a;
            r_b        <= i_operand_b;
        end else begin
            r_selector <= r_selector;
            r_a        <= r_a;
            r_b        <= r_b;
        end
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_less = ($signed(r_a) < $signed(r_b));

    // Single-cycle datapath evaluated on the latched operands during EXEC.
    always_comb begin
        w_exec_result  = {WIDTH{1'b0}};
        w_exec_carry   = 1'b0;
        w_exec_illegal = !is_legal_op(r_selector);
        case (r_selector)
            OP_AND:  w_exec_result = r_a & r_b;
            OP_OR:   w_exec_result = r_a | r_b;
            OP_XOR:  w_exec_result = r_a ^ r_b;
            OP_ADD: begin
                w_exec_result = w_sum[WIDTH-1:0];
                w_exec_carry  = w_sum[WIDTH];
            end
            OP_LESS: w_exec_result = {{(WIDTH-1){1'b0}}, w_less};
            OP_MUL:  w_exec_result = {WIDTH{1'b0}};
            default: w_exec_result = {WIDTH{1'b0}};
        endcase
    end

    // Result and flag registers; they hold outside the finishing edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result  <= {WIDTH{1'b0}};
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_result  <= w_exec_result;
            r_zero    <= (w_exec_result == {WIDTH{1'b0}});
            r_carry   <= w_exec_carry;
            r_illegal <= w_exec_illegal;
        end else if ((r_state == ST_MUL) && w_mul_done) begin
            r_result  <= w_mul_product;
            r_zero    <= (w_mul_product == {WIDTH{1'b0}});
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_result  <= r_result;
            r_zero    <= r_zero;
            r_carry   <= r_carry;
            r_illegal <= r_illegal;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer (WIDTH = 24). Inputs change and outputs
// are sampled on the falling clock edge; each scenario task carries its own
// hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [2:0]   selector;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_opcode    (opcode),
        .i_operand_a (opa),
        .i_operand_b (opb),
        .o_selector  (selector),
        .o_busy      (busy),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_zero      (zero),
        .o_carry     (carry),
        .o_illegal   (illegal)
    );

    // Present one request for a single edge, then scramble the inputs so the
    // operation must rely on the latched copies. Returns one falling edge
    // after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = op;
        opa      = a;
        opb      = b;
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = ~op;
        opa      = ~a;
        opb      = ~b;
    endtask

    task automatic test_reset;
        logic [W+8:0] obs;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 3'b000;
        opa       = {W{1'b0}};
        opb       = {W{1'b0}};
        #22;
        obs = {in_ready, busy, out_valid, selector, result, zero, carry, illegal};
        n_tests++;
        if (obs !== {1'b1, 1'b0, 1'b0, 3'b000, {W{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs,
                     {1'b1, 1'b0, 1'b0, 3'b000, {W{1'b0}}, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_add;
        out_ready = 1'b1;
        send(3'b010, 24'hFFFFFF, 24'h000001);
        n_tests++;
        if ({in_ready, busy, out_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL add_exec_phase: got %b expected 010", {in_ready, busy, out_valid});
        end
        @(negedge clk);
        n_tests++;
        if ({in_ready, busy, out_valid, result, zero, carry, selector} !==
            {1'b0, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b1, 3'b010}) begin
            n_fail++;
            $display("FAIL add_wrap: got rdy%b bsy%b ov%b res %h z%b c%b sel %b expected ov1 res 000000 z1 c1 sel 010",
                     in_ready, busy, out_valid, result, zero, carry, selector);
        end
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_single_valid: got rdy/ov %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_less;
        out_ready = 1'b1;
        send(3'b011, 24'h800000, 24'h000001);
        @(negedge clk);
        n_tests++;
        if ({out_valid, result, zero, carry} !== {1'b1, 24'h000001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL less_neg_lt_pos: got ov%b res %h z%b c%b expected ov1 res 000001 z0 c0",
                     out_valid, result, zero, carry);
        end
        send(3'b011, 24'h000001, 24'h800000);
        @(negedge clk);
        n_tests++;
        if ({out_valid, result, zero, carry} !== {1'b1, 24'h000000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL less_pos_lt_neg: got ov%b res %h z%b c%b expected ov1 res 000000 z1 c0",
                     out_valid, result, zero, carry);
        end
        @(negedge clk);
    endtask

    task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp, input logic exp_zero);
        int idx;
        int busy_cnt;
        int rdy_bad;
        out_ready = 1'b1;
        send(3'b100, a, b);
        idx      = 0;
        busy_cnt = 0;
        rdy_bad  = 0;
        while (!out_valid && idx < 40) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_bad++;
            @(negedge clk);
            idx++;
        end
        n_tests++;
        if (idx !== 24 || busy_cnt !== 24 || rdy_bad !== 0) begin
            n_fail++;
            $display("FAIL mul_latency %h*%h: got valid_at %0d busy %0d ready_hi %0d expected 24 24 0",
                     a, b, idx, busy_cnt, rdy_bad);
        end
        n_tests++;
        if ({out_valid, busy, result, zero, carry, selector} !==
            {1'b1, 1'b0, exp, exp_zero, 1'b0, 3'b100}) begin
            n_fail++;
            $display("FAIL mul_result %h*%h: got ov%b bsy%b res %h z%b c%b sel %b expected res %h z%b",
                     a, b, out_valid, busy, result, zero, carry, selector, exp, exp_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int bad;
        out_ready = 1'b0;
        send(3'b101, 24'hAAAAAA, 24'h555555);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({out_valid, in_ready, busy, result} !== {1'b1, 1'b0, 1'b0, 24'hFFFFFF}) bad++;
            in_valid = (i % 2 == 0);
            opcode   = 3'b010;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++;
        if (bad !== 0 || out_valid !== 1'b1 || result !== 24'hFFFFFF) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %0d unstable cycles, ov%b res %h expected 0, ov1 res FFFFFF",
                     bad, out_valid, result);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_release: got ov/rdy %b expected 01", {out_valid, in_ready});
        end
        @(negedge clk);
        n_tests++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL backpressure_no_queue: got %b expected 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_illegal;
        out_ready = 1'b1;
        send(3'b111, 24'd5, 24'd3);
        @(negedge clk);
        n_tests++;
        if ({out_valid, illegal, zero, carry, result, selector} !==
            {1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 3'b111}) begin
            n_fail++;
            $display("FAIL illegal_111: got ov%b ill%b z%b c%b res %h sel %b expected ill1 z1 res 0 sel 111",
                     out_valid, illegal, zero, carry, result, selector);
        end
        send(3'b110, 24'd5, 24'd3);
        @(negedge clk);
        n_tests++;
        if ({out_valid, illegal, zero, result, selector} !==
            {1'b1, 1'b1, 1'b1, 24'h000000, 3'b110}) begin
            n_fail++;
            $display("FAIL illegal_110: got ov%b ill%b z%b res %h sel %b expected ill1 z1 res 0 sel 110",
                     out_valid, illegal, zero, result, selector);
        end
        send(3'b001, 24'd5, 24'd3);
        @(negedge clk);
        n_tests++;
        if ({out_valid, illegal, zero, result, selector} !==
            {1'b1, 1'b0, 1'b0, 24'h000007, 3'b001}) begin
            n_fail++;
            $display("FAIL or_after_illegal: got ov%b ill%b z%b res %h sel %b expected ill0 z0 res 000007 sel 001",
                     out_valid, illegal, zero, result, selector);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul;
        logic [W+8:0] obs;
        out_ready = 1'b1;
        send(3'b100, 24'd7, 24'd9);
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_mul_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        obs = {in_ready, busy, out_valid, selector, result, zero, carry, illegal};
        n_tests++;
        if (obs !== {1'b1, 1'b0, 1'b0, 3'b000, {W{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_mul_reset: got %h expected %h", obs,
                     {1'b1, 1'b0, 1'b0, 3'b000, {W{1'b0}}, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        opcode   = 3'b010;
        opa      = 24'd1;
        opb      = 24'd1;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if ({in_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL first_accept_after_reset: got rdy/bsy %b expected 01", {in_ready, busy});
        end
        @(negedge clk);
        n_tests++;
        if ({out_valid, result, carry, zero} !== {1'b1, 24'h000002, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_after_reset: got ov%b res %h c%b z%b expected ov1 res 000002 c0 z0",
                     out_valid, result, carry, zero);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [8:0] ov_mask;
        logic [8:0] rdy_mask;
        int         bad_res;
        out_ready = 1'b1;
        ov_mask   = 9'b000000000;
        rdy_mask  = 9'b000000000;
        bad_res   = 0;
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = 3'b010;
        opa      = 24'd10;
        opb      = 24'd20;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ov_mask[i]  = out_valid;
            rdy_mask[i] = in_ready;
            if (out_valid && result !== 24'd30) bad_res++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (ov_mask !== 9'b010010010 || rdy_mask !== 9'b100100100) begin
            n_fail++;
            $display("FAIL back_to_back_interval: got ov %b rdy %b expected ov 010010010 rdy 100100100",
                     ov_mask, rdy_mask);
        end
        n_tests++;
        if (bad_res !== 0) begin
            n_fail++;
            $display("FAIL back_to_back_result: got %0d wrong results expected 0", bad_res);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_less();
        test_mul(24'h000123, 24'h000456, 24'h04EDC2, 1'b0);
        test_mul(24'hFFFFFF, 24'hFFFFFF, 24'h000001, 1'b0);
        test_mul(24'h800000, 24'h000002, 24'h000000, 1'b1);
        test_backpressure();
        test_illegal();
        test_reset_mid_mul();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
